// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-channel weighted arbiter: FSM state
// encodings and the credit counter width.
package mux_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServe0 = 2'd1,
    StServe1 = 2'd2
  } state_e;

endpackage

// File: rtl/mux_arb.sv
// Two-channel weighted round-robin arbiter that drives an external 2:1 mux.
// Each cycle it pops at most one upstream FIFO; channel x may take up to Wx
// back-to-back grants before the other channel gets a turn, and a switch
// between channels never costs an idle cycle.
// Optional feature: define MUX_ARB_STRICT_PRIO_EN to make channel 0 a strict
// priority winner (weights and the credit counter are then unused).
module mux_arb
  import mux_arb_pkg::*;
#(
  parameter int unsigned W0 = 2,
  parameter int unsigned W1 = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic empty0,
  input  logic empty1,
  input  logic pause,
  output logic pop0,
  output logic pop1,
  output logic selector,
  output logic grant_valid
);

  // Weights are compared unsigned at counter width.
  localparam logic [CNT_W-1:0] W0C = CNT_W'(W0);
  localparam logic [CNT_W-1:0] W1C = CNT_W'(W1);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_sel;
  logic             w_elig0;
  logic             w_elig1;
  logic             w_grant0;
  logic             w_grant1;

  assign w_elig0 = ~empty0 & ~pause;
  assign w_elig1 = ~empty1 & ~pause;

  // Next-state, next credit count and grant decision.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
`ifdef MUX_ARB_STRICT_PRIO_EN
    // Channel 0 always wins; the state only records who was served last.
    if (w_elig0) begin
      w_grant0     = 1'b1;
      w_state_next = StServe0;
    end else if (w_elig1) begin
      w_grant1     = 1'b1;
      w_state_next = StServe1;
    end
`else
    case (r_state)
      StIdle: begin
        if (w_elig0) begin
          w_grant0     = 1'b1;
          w_state_next = StServe0;
          w_cnt_next   = CNT_W'(1);
        end else if (w_elig1) begin
          w_grant1     = 1'b1;
          w_state_next = StServe1;
          w_cnt_next   = CNT_W'(1);
        end
      end
      StServe0: begin
        if (w_elig0 && (r_cnt < W0C)) begin
          w_grant0   = 1'b1;
          w_cnt_next = r_cnt + CNT_W'(1);
        end else if (w_elig1) begin
          // Credits spent or channel 0 dried up: hand over without a bubble.
          w_grant1     = 1'b1;
          w_state_next = StServe1;
          w_cnt_next   = CNT_W'(1);
        end else if (w_elig0) begin
          // Other side idle: start a fresh round on the same channel.
          w_grant0   = 1'b1;
          w_cnt_next = CNT_W'(1);
        end
      end
      StServe1: begin
        if (w_elig1 && (r_cnt < W1C)) begin
          w_grant1   = 1'b1;
          w_cnt_next = r_cnt + CNT_W'(1);
        end else if (w_elig0) begin
          w_grant0     = 1'b1;
          w_state_next = StServe0;
          w_cnt_next   = CNT_W'(1);
        end else if (w_elig1) begin
          w_grant1   = 1'b1;
          w_cnt_next = CNT_W'(1);
        end
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
`endif
  end

  // Outputs are forced low while reset is high, whatever the inputs do.
  always_comb begin
    pop0        = w_grant0 & ~reset;
    pop1        = w_grant1 & ~reset;
    grant_valid = pop0 | pop1;
    if (reset) begin
      selector = 1'b0;
    end else if (w_grant0 | w_grant1) begin
      selector = w_grant1;
    end else begin
      selector = r_sel;
    end
  end

  // State, credit count and held selector; all hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_grant0 | w_grant1) begin
        r_sel <= w_grant1;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb.sv
// Self-checking bench for mux_arb (W0=2, W1=1). A behavioural model tracks
// the last-served channel and how many consecutive grants it has had in the
// current round; the compare process checks every cycle against the model
// and, where the stimulus supplies one, against a hand-computed literal.
module tb_mux_arb;

  logic clk = 1'b0;
  logic reset, empty0, empty1, pause;
  logic pop0, pop1, selector, grant_valid;

  always #5 clk = ~clk;

  mux_arb #(
    .W0(2),
    .W1(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .empty0     (empty0),
    .empty1     (empty1),
    .pause      (pause),
    .pop0       (pop0),
    .pop1       (pop1),
    .selector   (selector),
    .grant_valid(grant_valid)
  );

  int n_err = 0;
  int n_chk = 0;

  // Literal expectation for the current cycle, set by the stimulus.
  bit    lit_en = 1'b0;
  logic  lit_p0, lit_p1, lit_sel;
  string lit_name = "";

  // Model: last served channel (-1 = none since reset) and run length.
  int   m_last = -1;
  int   m_run  = 0;
  logic m_sel  = 1'b0;
  int   wgt[2] = '{2, 1};

  task automatic check(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  // Compare process: inputs are stable from #1 after posedge until the next
  // posedge, so the model advances here to the post-edge state.
  always @(negedge clk) begin : compare
    bit   e[2];
    int   g, x, o;
    logic ep0, ep1, esel;
    e[0] = !empty0 && !pause;
    e[1] = !empty1 && !pause;
    g = -1;
    if (!reset) begin
`ifdef MUX_ARB_STRICT_PRIO_EN
      g = e[0] ? 0 : (e[1] ? 1 : -1);
`else
      if (m_last < 0) begin
        g = e[0] ? 0 : (e[1] ? 1 : -1);
      end else begin
        x = m_last;
        o = 1 - x;
        if (e[x] && m_run < wgt[x]) g = x;
        else if (e[o]) g = o;
        else if (e[x]) g = x;
      end
`endif
    end
    ep0  = (g == 0);
    ep1  = (g == 1);
    esel = reset ? 1'b0 : ((g >= 0) ? (g == 1) : m_sel);
    check("model_pop0", pop0, ep0);
    check("model_pop1", pop1, ep1);
    check("model_selector", selector, esel);
    check("model_grant_valid", grant_valid, ep0 | ep1);
    if (lit_en) begin
      check({lit_name, "_pop0"}, pop0, lit_p0);
      check({lit_name, "_pop1"}, pop1, lit_p1);
      check({lit_name, "_selector"}, selector, lit_sel);
    end
    if (reset) begin
      m_last = -1;
      m_run  = 0;
      m_sel  = 1'b0;
    end else if (g >= 0) begin
      if (g == m_last && m_run < wgt[g]) m_run++;
      else m_run = 1;
      m_last = g;
      m_sel  = (g == 1);
    end
  end

  task automatic drv(input logic r, input logic e0, input logic e1, input logic p);
    @(posedge clk);
    #1;
    reset  = r;
    empty0 = e0;
    empty1 = e1;
    pause  = p;
    lit_en = 1'b0;
  endtask

  task automatic lit(input logic r, input logic e0, input logic e1, input logic p,
                     input logic l0, input logic l1, input logic ls, input string nm);
    drv(r, e0, e1, p);
    lit_en   = 1'b1;
    lit_p0   = l0;
    lit_p1   = l1;
    lit_sel  = ls;
    lit_name = nm;
  endtask

  initial begin
    reset  = 1'b1;
    empty0 = 1'b0;
    empty1 = 1'b0;
    pause  = 1'b0;
    // Reset held two cycles with both FIFOs non-empty: nothing pops.
    lit_en   = 1'b1;
    lit_p0   = 1'b0;
    lit_p1   = 1'b0;
    lit_sel  = 1'b0;
    lit_name = "reset0";
    lit(1, 0, 0, 0, 0, 0, 0, "reset1");
`ifndef MUX_ARB_STRICT_PRIO_EN
    // Release: weighted sequence 0,0,1,0,0,1.
    lit(0, 0, 0, 0, 1, 0, 0, "wrr_g0");
    lit(0, 0, 0, 0, 1, 0, 0, "wrr_g1");
    lit(0, 0, 0, 0, 0, 1, 1, "wrr_g2");
    lit(0, 0, 0, 0, 1, 0, 0, "wrr_g3");
    lit(0, 0, 0, 0, 1, 0, 0, "wrr_g4");
    lit(0, 0, 0, 0, 0, 1, 1, "wrr_g5");
    // Only channel 1 has data: it is served every cycle.
    lit(1, 0, 0, 0, 0, 0, 0, "rst_a");
    for (int i = 0; i < 4; i++) lit(0, 1, 0, 0, 0, 1, 1, "only_ch1");
    // Nothing eligible: selector holds 1.
    lit(0, 1, 1, 0, 0, 0, 1, "idle_hold_sel");
    lit(0, 1, 1, 0, 0, 0, 1, "idle_hold_sel");
    // Pause after the first ch0 grant keeps the remaining credit.
    lit(1, 0, 0, 0, 0, 0, 0, "rst_b");
    lit(0, 0, 0, 0, 1, 0, 0, "pause_pre");
    for (int i = 0; i < 3; i++) lit(0, 0, 0, 1, 0, 0, 0, "pause_hold");
    lit(0, 0, 0, 0, 1, 0, 0, "pause_post0");
    lit(0, 0, 0, 0, 0, 1, 1, "pause_post1");
    // Channel 0 empties after one grant: ch1 next cycle, no bubble.
    lit(1, 0, 0, 0, 0, 0, 0, "rst_c");
    lit(0, 0, 0, 0, 1, 0, 0, "switch_pre");
    lit(0, 1, 0, 0, 0, 1, 1, "switch_nobubble");
    // Reset mid-burst abandons credits; pause/empty during reset ignored.
    lit(1, 0, 0, 0, 0, 0, 0, "rst_d");
    lit(0, 1, 0, 0, 0, 1, 1, "burst_pre0");
    lit(0, 0, 0, 0, 1, 0, 0, "burst_pre1");
    lit(1, 0, 0, 0, 0, 0, 0, "rst_mid");
    lit(0, 0, 0, 0, 1, 0, 0, "burst_post0");
    lit(0, 0, 0, 0, 1, 0, 0, "burst_post1");
    lit(0, 0, 0, 0, 0, 1, 1, "burst_post2");
`else
    // Strict priority: ch0 wins all ten cycles.
    for (int i = 0; i < 10; i++) lit(0, 0, 0, 0, 1, 0, 0, "strict_ch0");
`endif
    // Randomized traffic with occasional pause and reset.
    for (int i = 0; i < 3000; i++) begin
      drv(($urandom_range(63) == 0), ($urandom_range(3) == 0),
          ($urandom_range(3) == 0), ($urandom_range(7) == 0));
    end
    drv(0, 1, 1, 0);
    @(posedge clk);
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameter W0, default 2: credit weight of channel 0, legal range 1..15.
REQ-002 Parameter W1, default 1: credit weight of channel 1, legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 empty0  input  1  upstream channel-0 FIFO empty.
REQ-006 empty1  input  1  upstream channel-1 FIFO empty.
REQ-007 pause  input  1  downstream backpressure; no grant while high.
REQ-008 pop0  output  1  pops channel-0 FIFO this cycle (combinational).
REQ-009 pop1  output  1  pops channel-1 FIFO this cycle (combinational).
REQ-010 selector  output  1  drives the 2:1 mux select; equals the granted channel.
REQ-011 grant_valid  output  1  pop0 | pop1; drives the mux valid path.

Function
REQ-012 Eligibility SHALL be elig_i = ~empty_i & ~pause, evaluated in the same cycle; pop_i SHALL assert only when elig_i is high.
REQ-013 At most one of pop0/pop1 SHALL be high in any cycle; each grant SHALL last exactly one cycle.
REQ-014 FSM states SHALL be IDLE, SERVE0 and SERVE1, plus a 4-bit credit counter cnt.
REQ-015 IDLE: grant channel 0 if elig0, else channel 1 if elig1; on grant go to SERVEx with cnt=1; otherwise stay in IDLE.
REQ-016 SERVEx with elig_x and cnt<Wx: grant x and set cnt=cnt+1.
REQ-017 SERVEx with (cnt==Wx or ~elig_x) and elig_other: grant other, go to SERVEother, cnt=1; this SHALL cause zero bubble cycles.
REQ-018 SERVEx with cnt==Wx, elig_x and ~elig_other: grant x and set cnt=1 (new round).
REQ-019 No eligible channel (including pause=1): no grant; state, cnt and selector SHALL hold.
REQ-020 selector SHALL equal the granted channel in a grant cycle; otherwise it SHALL hold registered sel_q, which updates to the granted channel each grant.
REQ-021 cnt SHALL never exceed 15 or wrap; weights are compared unsigned at 4 bits.

Reset
REQ-022 While reset=1 at the rising edge: state=IDLE, cnt=0, sel_q=0.
REQ-023 While reset=1: pop0=pop1=grant_valid=0 and selector=0, regardless of the other inputs.
REQ-024 Reset asserted mid-burst SHALL abandon the remaining credits; the first grant after release follows the IDLE rule.

Configuration
REQ-025 Macro MUX_ARB_STRICT_PRIO_EN defined: channel 0 SHALL be granted every cycle elig0=1; channel 1 only when elig0=0. Weights and cnt are unused; the FSM still tracks the last-served state.
REQ-026 Macro undefined: weighted round-robin per REQ-015..REQ-021.

Structure
REQ-027 A shared package mux_arb_pkg SHALL hold the state encodings (IDLE=2'd0, SERVE0=2'd1, SERVE1=2'd2) and CNT_W=4.
REQ-028 The block SHALL be a single module with no sub-modules; it pairs externally with the existing 2:1 mux (selector, valid).

Verification
REQ-029 Reset held 2 cycles with empty0=empty1=0 -> pop0=pop1=0 and selector=0 during reset; pop0=1 in the first cycle after release.
REQ-030 W0=2, W1=1, both FIFOs non-empty, pause=0 -> grant sequence 0,0,1,0,0,1 and grant_valid=1 every cycle.
REQ-031 empty0=1, empty1=0 continuously -> pop1=1 and selector=1 every cycle, with cnt cycling 1,1,...
REQ-032 Both non-empty, pause=1 for 3 cycles after the first ch0 grant -> no pops and selector=0 held; after release the grants are 0,1 (credit preserved).
REQ-033 Ch0 empties after one grant while ch1 is non-empty -> pop1 in the very next cycle, with no idle cycle.
REQ-034 MUX_ARB_STRICT_PRIO_EN defined, both non-empty for 10 cycles -> pop0=1 in all 10 cycles and pop1 never asserts.
